// File: rtl/mult_seq_pkg.sv
// Shared types and size defaults for the digit-serial multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIGIT = 2;

  // Number of MUL cycles spent on one operand pair.
  function automatic int mul_cycles(input int width, input int digit);
    return (width / digit) * (width / digit);
  endfunction

endpackage

// File: rtl/mult_digit_core.sv
// Combinational DIGIT x DIGIT unsigned multiplier; the only arithmetic core the
// sequencer shares across all digit pairs.
module mult_digit_core #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0]   a,
  input  logic [DIGIT-1:0]   b,
  output logic [2*DIGIT-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mult_digit_sequencer.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier, result NDIG^2+1 cycles after accept.
// No overlap: in_ready stays low until the held result is taken with out_ready.
module mult_digit_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   out_p,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIG - 1);

  seq_state_e           state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [IDX_W-1:0]     i_q, j_q;
  logic [2*WIDTH-1:0]   acc_q, acc_sum, pp_ext;
  logic [DIGIT-1:0]     a_dig, b_dig;
  logic [2*DIGIT-1:0]   pp;
  logic                 accept, last_pair;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MUL) || (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign last_pair = (i_q == LAST) && (j_q == LAST);

  assign a_dig = a_q[i_q*DIGIT +: DIGIT];
  assign b_dig = b_q[j_q*DIGIT +: DIGIT];

  mult_digit_core #(.DIGIT(DIGIT)) u_core (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  // Digit pair (i,j) carries weight 2^(DIGIT*(i+j)).
  assign pp_ext  = (2*WIDTH)'(pp);
  assign acc_sum = acc_q + (pp_ext << (DIGIT * (int'(i_q) + int'(j_q))));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL:     if (last_pair) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
          end
        end
        MUL: begin
          acc_q <= acc_sum;
          // j is the inner index, i the outer one.
          if (j_q == LAST) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
          if (last_pair) out_p <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_digit_sequencer.sv
// Directed checks of the digit-serial multiplier at 4x4 and 8x8 sizes.
module tb_mult_digit_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] in_a, in_b;
  logic [7:0] out_p;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [7:0]  w_in_a, w_in_b;
  logic [15:0] w_out_p;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_digit_sequencer #(.WIDTH(4), .DIGIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_p     (out_p),
    .out_ready (out_ready),
    .busy      (busy)
  );

  mult_digit_sequencer #(.WIDTH(8), .DIGIT(2)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_a      (w_in_a),
    .in_b      (w_in_b),
    .in_ready  (w_in_ready),
    .out_valid (w_out_valid),
    .out_p     (w_out_p),
    .out_ready (w_out_ready),
    .busy      (w_busy)
  );

  // Presents one operand pair in an in_ready cycle (cycle t), then returns at the
  // first negedge with out_valid high; lat = cycles after t, -1 on timeout.
  task automatic do_job(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic [7:0] p);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!out_valid) lat = -1;
    p = out_p;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset4: rdy=%b vld=%b p=%0d busy=%b, required 1 0 0 0",
               in_ready, out_valid, out_p, busy);
    end
    n_assert++;
    if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_out_p !== 16'd0 || w_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: rdy=%b vld=%b p=%0d busy=%b, required 1 0 0 0",
               w_in_ready, w_out_valid, w_out_p, w_busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [7:0] p;
    out_ready = 1'b1;
    do_job(4'd15, 4'd15, lat, p);
    n_assert++;
    if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d, required 5", lat); end
    n_assert++;
    if (p !== 8'hE1) begin n_fail++; $display("FAIL basic_product: got %0d, required 225", p); end
    @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_return_idle: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] p;
    out_ready = 1'b0;
    do_job(4'd9, 4'd6, lat, p);
    n_assert++;
    if (lat !== 5 || p !== 8'd54) begin
      n_fail++; $display("FAIL bp_first: lat=%0d p=%0d, required 5 54", lat, p);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_assert++;
      if (out_valid !== 1'b1 || out_p !== 8'd54 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: vld=%b p=%0d rdy=%b busy=%b, required 1 54 0 1",
                 k, out_valid, out_p, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%b vld=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_q[$];
    logic [7:0] exp_p;
    int idx = 0, got = 0, cyc = 0, last_acc = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = 4'd0; in_b = 4'd0;
    while (got < 256 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        n_assert++;
        exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (out_p !== exp_p) begin
          n_fail++; $display("FAIL sweep_product[%0d]: got %0d, required %0d", got, out_p, exp_p);
        end
        got++;
      end
      if (in_ready && idx < 256) begin
        in_a = idx[7:4]; in_b = idx[3:0];
        exp_q.push_back({4'd0, in_a} * {4'd0, in_b});
        if (last_acc >= 0) begin
          n_assert++;
          if (cyc - last_acc !== 6) begin
            n_fail++; $display("FAIL sweep_interval[%0d]: got %0d, required 6", idx, cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
      end else begin
        // Scrambled operands while not ready must never be latched.
        in_a = ~idx[3:0] ^ cyc[3:0];
        in_b = idx[7:4] + cyc[3:0];
        if (idx >= 256) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_assert++;
    if (got !== 256) begin n_fail++; $display("FAIL sweep_count: got %0d, required 256", got); end
  endtask

  task automatic test_abort();
    int lat; logic [7:0] p;
    out_ready = 1'b1;
    @(negedge clk);
    in_a = 4'd7; in_b = 4'd11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b, required 1", busy); end
    rst = 1'b1;
    #1;
    n_assert++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: rdy=%b vld=%b p=%0d busy=%b, required 1 0 0 0",
               in_ready, out_valid, out_p, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    do_job(4'd3, 4'd5, lat, p);
    n_assert++;
    if (lat !== 5 || p !== 8'd15) begin
      n_fail++; $display("FAIL abort_next: lat=%0d p=%0d, required 5 15", lat, p);
    end
  endtask

  task automatic test_edges();
    logic [3:0] ta[3] = '{4'd0, 4'd13, 4'd1};
    logic [3:0] tb[3] = '{4'd13, 4'd0, 4'd1};
    logic [7:0] tp[3] = '{8'd0, 8'd0, 8'd1};
    int lat; logic [7:0] p;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_job(ta[k], tb[k], lat, p);
      n_assert++;
      if (lat !== 5 || p !== tp[k]) begin
        n_fail++;
        $display("FAIL edge[%0d] %0d*%0d: lat=%0d p=%0d, required 5 %0d", k, ta[k], tb[k], lat, p, tp[k]);
      end
    end
  endtask

  task automatic test_wide();
    int lat = 1;
    w_out_ready = 1'b1;
    @(negedge clk);
    w_in_a = 8'd255; w_in_b = 8'd255; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    while (!w_out_valid && lat < 60) begin @(negedge clk); lat++; end
    n_assert++;
    if (!w_out_valid || lat !== 17) begin
      n_fail++; $display("FAIL wide_latency: got %0d, required 17", w_out_valid ? lat : -1);
    end
    n_assert++;
    if (w_out_p !== 16'd65025) begin
      n_fail++; $display("FAIL wide_product: got %0d, required 65025", w_out_p);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sweep();
    test_abort();
    test_edges();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_digit_sequencer.md
Name: mult_digit_sequencer

Overview:
- Sequential multiplier controller that time-shares one DIGIT x DIGIT partial-product core across all digit pairs of a WIDTH x WIDTH multiply.
- Accumulates the shifted partial products, ll/lh/hl/hh at default size.
- Serial, area-lean counterpart to the fully parallel 4-bit composite multipliers.
- Sits between an operand producer and result consumer using valid/ready handshakes.

Parameters:
- WIDTH, 4, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, digit width in bits; this is the shared core size.
- NDIG, WIDTH/DIGIT, derived constant (localparam): digits per operand.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_ready  out  1  block can accept an operand pair.
- out_valid  out  1  result valid.
- out_p  out  2*WIDTH  unsigned product A*B.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in MUL or DONE state.

Behaviour:
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_p=0; busy=0; accumulator, digit indices and operand registers = 0. Reset asserted mid-operation aborts the multiply immediately and discards it, with no result produced.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_b, clear acc, set i=0, j=0, go to MUL.
  - MUL: each cycle the core computes pp = A_digit[i] * B_digit[j]. acc <= acc + (pp << DIGIT*(i+j)). The 2*DIGIT-bit pp is zero-extended to 2*WIDTH before the shift.
    - Index order: j inner, i outer: (0,0),(0,1),(1,0),(1,1) for the default size.
    - After pair (NDIG-1,NDIG-1), go to DONE.
  - DONE: out_valid=1 and out_p=acc, held stable. On out_ready, go to IDLE.
- Latency:
  - Handshake in cycle t; MUL occupies cycles t+1 .. t+NDIG^2.
  - out_valid first high in cycle t+NDIG^2+1, which is 5 for the default size.
  - No back-to-back overlap: in_ready=0 from the accept edge until the cycle after out_ready is sampled in DONE. Minimum initiation interval is NDIG^2+2 cycles.
- Input rules:
  - in_valid while in_ready=0 is ignored; the operands are not latched.
  - in_a/in_b are sampled only at the accept edge. Changes during MUL have no effect.
- Output rules: out_p and out_valid do not change while out_valid=1 and out_ready=0.
- Width: acc is 2*WIDTH bits, and the final sum never exceeds (2^WIDTH-1)^2, so no overflow. Arithmetic is purely unsigned.
- out_valid and out_p are registered. in_ready and busy decode directly from the state register.
- Invalid state encoding returns to IDLE.

Decomposition:
- Package mult_seq_pkg:
  - State enum {IDLE, MUL, DONE}.
  - Default WIDTH/DIGIT constants.
  - Function or constant for the cycle count NDIG*NDIG.
- Sub-module mult_digit_core: combinational DIGIT x DIGIT unsigned multiplier (A, B -> P of 2*DIGIT bits). It is instantiated once and is swappable for any equivalent 2x2 core implementation.
- The top holds the FSM, digit counters, operand registers and accumulator.

Test Plan:
- Reset, then in_a=15, in_b=15, in_valid pulse, out_ready=1 -> out_valid high exactly 5 cycles after accept, out_p=225 (0xE1), then in_ready back to 1.
- in_a=9, in_b=6 with out_ready held 0 for 10 cycles -> out_p=54 held stable with out_valid=1 throughout. in_ready stays 0 until the cycle after out_ready rises.
- Exhaustive sweep of all 256 operand pairs, with in_valid asserted continuously and out_ready=1 -> each result equals A*B. Accepts occur every 6 cycles; operand changes while in_ready=0 are ignored.
- Accept in_a=7, in_b=11, assert rst during the 2nd MUL cycle -> all outputs at reset values immediately. Then accept in_a=3, in_b=5 -> out_p=15 with no residue from the aborted job.
- Edge operands: 0*13, 13*0 and 1*1 -> out_p=0, 0, 1 respectively, each with the standard 5-cycle latency.
- WIDTH=8, DIGIT=2 build: in_a=255, in_b=255 -> out_p=65025, out_valid 17 cycles after accept.
